// File: rtl/masked_match_pipe.sv
// Pipelined masked equality detector with runtime pattern/mask, a valid pipeline,
// a saturating match counter and a non-overlapping consecutive-match run detector.
module masked_match_pipe #(
    parameter int               WIDTH         = 10,
    parameter int               METHOD        = 1,
    parameter int               CHUNK         = 6,
    parameter logic [WIDTH-1:0] RESET_PATTERN = 10'b1010111010,
    parameter int               CNT_WIDTH     = 16,
    parameter int               RUN_LEN       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [WIDTH-1:0]     cfg_pattern,
    input  logic [WIDTH-1:0]     cfg_mask,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 count_clr,
    output logic                 match,
    output logic                 match_valid,
    output logic                 run_hit,
    output logic [CNT_WIDTH-1:0] match_count
);

    localparam int RUN_W = $clog2(RUN_LEN + 1);

    logic [WIDTH-1:0]     pattern_q, mask_q;
    logic [WIDTH-1:0]     diff;
    logic                 match_q, valid_q;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [RUN_W-1:0]     run_q, run_d;
    logic                 hit_q, hit_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; this is what makes a same-cycle word see the old pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_q <= RESET_PATTERN;
            mask_q    <= '1;
        end else if (cfg_we) begin
            pattern_q <= cfg_pattern;
            mask_q    <= cfg_mask;
        end
    end

    assign diff = (din ^ pattern_q) & mask_q;

    generate
        if (METHOD == 0) begin : g_flat
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    match_q <= 1'b0;
                    valid_q <= 1'b0;
                end else begin
                    match_q <= ~|diff;
                    valid_q <= din_valid;
                end
            end
        end else begin : g_chunk
            localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;

            logic [NCHUNK-1:0] part_d, part_q;
            logic              valid1_q;

            // The last chunk is clipped to WIDTH when CHUNK does not divide it.
            for (genvar c = 0; c < NCHUNK; c++) begin : g_part
                localparam int LO = c * CHUNK;
                localparam int HI = (LO + CHUNK > WIDTH) ? WIDTH - 1 : LO + CHUNK - 1;
                assign part_d[c] = ~|diff[HI:LO];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    part_q   <= '0;
                    valid1_q <= 1'b0;
                    match_q  <= 1'b0;
                    valid_q  <= 1'b0;
                end else begin
                    part_q   <= part_d;
                    valid1_q <= din_valid;
                    match_q  <= &part_q;
                    valid_q  <= valid1_q;
                end
            end
        end
    endgenerate

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        count_d = count_q;
        run_d   = run_q;
        hit_d   = 1'b0;
        if (count_clr) begin
            count_d = '0;
            run_d   = '0;
        end else if (valid_q) begin
            if (match_q) begin
                if (count_q != '1) count_d = count_q + CNT_WIDTH'(1);
                // Reaching RUN_LEN fires a pulse and restarts the run, so hits never overlap.
                if (run_q + RUN_W'(1) == RUN_W'(RUN_LEN)) begin
                    run_d = '0;
                    hit_d = 1'b1;
                end else begin
                    run_d = run_q + RUN_W'(1);
                end
            end else begin
                run_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            run_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            run_q   <= run_d;
            hit_q   <= hit_d;
        end
    end

    assign match       = match_q;
    assign match_valid = valid_q;
    assign run_hit     = hit_q;
    assign match_count = count_q;

endmodule
